// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: write port, packed read addresses/data and status.
// master = decode/write-back side, slave = register file.
interface regfile_multiport_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                       ready;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          par_err;

  modport master (
    input  ready, rd_data, par_err,
    output wr_en, wr_addr, wr_data, rd_addr
  );

  modport slave (
    output ready, rd_data, par_err,
    input  wr_en, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/regfile_multiport.sv
// NUM_RD-read / 1-write register file, write-first forwarding, optional zero register,
// post-reset clear sequencer. Optional per-entry parity under `REGFILE_PARITY_EN.
module regfile_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_multiport_if.slave  bus
);
  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
`ifdef REGFILE_PARITY_EN
  localparam int unsigned     ENTRY_W  = DATA_W + 1;
`else
  localparam int unsigned     ENTRY_W  = DATA_W;
`endif

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic                ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [ENTRY_W-1:0]  mem_wdata;

  // Storage carries no reset so it can map to non-resettable block RAM.
  logic [ENTRY_W-1:0]  mem_q [DEPTH];

  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        par_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      if (clr_cnt_q == CLR_LAST) state_d = RUN;
    end
  end

  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[ADDR_W-1:0];
    end else begin
      ready  = 1'b1;
      mem_we = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
`ifdef REGFILE_PARITY_EN
      mem_wdata = {^bus.wr_data, bus.wr_data};
`else
      mem_wdata = bus.wr_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    logic [ADDR_W-1:0]  ra;
    logic [ENTRY_W-1:0] ent;
    rd_data_d = '0;
    par_err_d = '0;
    ra        = '0;
    ent       = '0;
    if (state_q == RUN) begin
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        ra  = bus.rd_addr[p*ADDR_W +: ADDR_W];
        ent = mem_q[ra];
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_data_d[p*DATA_W +: DATA_W] = '0;
        end else if (bus.wr_en && (bus.wr_addr == ra)) begin
          rd_data_d[p*DATA_W +: DATA_W] = bus.wr_data;
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = ent[DATA_W-1:0];
          // Stored even parity bit XOR data is 1 exactly when the entry is corrupted.
          par_err_d[p] = ^ent;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign bus.ready   = ready;
  assign bus.rd_data = rd_data_q;

`ifdef REGFILE_PARITY_EN
  logic [NUM_RD-1:0] par_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_err_q <= '0;
    else       par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par  = ^par_err_d;
  assign bus.par_err = '0;
`endif
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: dut0 has ZERO_REG=1, dut1 ZERO_REG=0, same stimulus.
module tb_regfile_multiport;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus1 ();

  assign bus1.wr_en   = bus0.wr_en;
  assign bus1.wr_addr = bus0.wr_addr;
  assign bus1.wr_data = bus0.wr_data;
  assign bus1.rd_addr = bus0.rd_addr;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus0.rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus0.wr_en   = en;
    bus0.wr_addr = a;
    bus0.wr_data = d;
  endtask

  function automatic logic [31:0] rd0(input logic [63:0] v);
    return v[31:0];
  endfunction

  function automatic logic [31:0] rd1(input logic [63:0] v);
    return v[63:32];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd0);

    // 1: reset, clear duration, all entries zero
    reset = 1'b1;
    repeat (3) step();
    check("reset_ready", {31'd0, bus0.ready}, 32'd0);
    check("reset_rd0", rd0(bus0.rd_data), 32'd0);
    check("reset_rd1", rd1(bus0.rd_data), 32'd0);
    check("reset_perr", {30'd0, bus0.par_err}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (!bus0.ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("clear_cycles", cnt, 32'd32);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      step();
      check($sformatf("init_p0_x%0d", i), rd0(bus0.rd_data), 32'd0);
      check($sformatf("init_p1_x%0d", 31 - i), rd1(bus0.rd_data), 32'd0);
    end

    // 2: write then read both ports
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    set_rd(5'd1, 5'd2);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd5);
    step();
    check("x5_p0", rd0(bus0.rd_data), 32'hDEADBEEF);
    check("x5_p1", rd1(bus0.rd_data), 32'hDEADBEEF);
    check("x5_perr", {30'd0, bus0.par_err}, 32'd0);

    // 3: same-edge forwarding
    set_wr(1'b1, 5'd7, 32'h12345678);
    set_rd(5'd7, 5'd5);
    step();
    check("fwd_p0", rd0(bus0.rd_data), 32'h12345678);
    check("fwd_p1_other", rd1(bus0.rd_data), 32'hDEADBEEF);
    set_wr(1'b0, 5'd0, 32'h0);
    step();
    check("x7_stored", rd0(bus0.rd_data), 32'h12345678);

    // 4: zero register
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(5'd7, 5'd0);
    step();
    check("zr1_same", rd1(bus0.rd_data), 32'h0);
    check("zr0_same", rd1(bus1.rd_data), 32'hFFFFFFFF);
    set_wr(1'b0, 5'd0, 32'h0);
    step();
    check("zr1_after", rd1(bus0.rd_data), 32'h0);
    check("zr0_after", rd1(bus1.rd_data), 32'hFFFFFFFF);

    // boundary: top entry, port independence
    set_wr(1'b1, 5'd31, 32'h80000001);
    set_rd(5'd5, 5'd7);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd31, 5'd7);
    step();
    check("x31_p0", rd0(bus0.rd_data), 32'h80000001);
    check("x7_p1", rd1(bus0.rd_data), 32'h12345678);

    // 5: reset mid-clear restarts, write during clear dropped
    set_wr(1'b1, 5'd3, 32'hA5A5A5A5);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd3);
    step();
    check("x3_before", rd0(bus0.rd_data), 32'hA5A5A5A5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("midclr_ready", {31'd0, bus0.ready}, 32'd0);
    reset = 1'b1;
    step();
    check("repulse_rd", rd0(bus0.rd_data), 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (!bus0.ready && cnt < 100) begin
      step();
      cnt++;
      if (cnt == 20) begin
        set_wr(1'b1, 5'd3, 32'h11111111);
        set_rd(5'd3, 5'd3);
      end else if (cnt == 21) begin
        check("clear_no_fwd", rd0(bus0.rd_data), 32'd0);
        set_wr(1'b0, 5'd0, 32'h0);
      end
    end
    check("reclear_cycles", cnt, 32'd32);
    set_rd(5'd3, 5'd5);
    step();
    check("x3_cleared", rd0(bus0.rd_data), 32'd0);
    check("x5_cleared", rd1(bus0.rd_data), 32'd0);

`ifdef REGFILE_PARITY_EN
    // 6: parity error on a corrupted entry
    set_wr(1'b1, 5'd9, 32'h1);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd9, 5'd5);
    step();
    check("x9_clean_perr", {30'd0, bus0.par_err}, 32'd0);
    dut0.mem_q[9][0] = ~dut0.mem_q[9][0];
    step();
    check("x9_perr0", {31'd0, bus0.par_err[0]}, 32'd1);
    check("x9_data", rd0(bus0.rd_data), 32'h0);
    check("x5_perr1", {31'd0, bus0.par_err[1]}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
